// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Parametrised pipeline stage register with a valid/ready
//            handshake, freeze/flush controls and a global enable. It has an
//            optional one-entry skid buffer. Empty entries read as all-zero,
//            so an empty stage presents a NOP downstream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W : payload width in bits
//   SKID   : 1 = main + skid entries, in_ready registered; 0 = single entry
//   CNT_W  : width of the saturating flush-drop counter
// Ports
//   CLK        in   1       clock, rising edge
//   nRST       in   1       asynchronous active-low reset
//   en         in   1       global enable (0 freezes all state)
//   freeze     in   1       hold contents (qualified by en)
//   flush      in   1       discard contents (qualified by en, loses to freeze)
//   in_valid   in   1       upstream payload valid
//   in_data    in   DATA_W  upstream payload
//   in_ready   out  1       stage accepts a payload this cycle
//   out_valid  out  1       out_data is valid
//   out_data   out  DATA_W  head payload, zero when out_valid=0
//   out_ready  in   1       downstream accepts the head payload
//   drop_cnt   out  CNT_W   valid entries discarded by flush (saturating)
// ============================================================================
module pipe_stage_buf #(
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] md_q;
  logic [DATA_W-1:0] md_d;
  logic [DATA_W-1:0] sd_q;
  logic [DATA_W-1:0] sd_d;
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  drop_d;

  logic              mv;
  logic              sv;
  logic              act;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    drop_sum;

  assign mv   = (state_q != ST_EMPTY);
  assign sv   = (state_q == ST_TWO);
  assign act  = en & ~freeze & ~flush;
  assign push = act & in_valid & in_ready;
  assign pop  = act & mv & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Depends only on registered state: no path from out_ready.
      assign in_ready = (state_q != ST_TWO);
    end else begin : g_noskid
      // Combinational path out_ready -> in_ready: a full single-entry stage
      // can accept only when the head leaves in the same cycle.
      assign in_ready = ~mv | (out_ready & act);
    end
  endgenerate

  // One extra bit catches overflow so the counter can saturate.
  assign drop_sum = {1'b0, drop_q} + {{CNT_W{1'b0}}, mv} + {{CNT_W{1'b0}}, sv};

  always_comb begin
    state_d = state_q;
    md_d    = md_q;
    sd_d    = sd_q;
    drop_d  = drop_q;
    if (en && !freeze) begin
      if (flush) begin
        state_d = ST_EMPTY;
        md_d    = '0;
        sd_d    = '0;
        drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (push) begin
              state_d = ST_ONE;
              md_d    = in_data;
            end
          end
          ST_ONE: begin
            if (push && pop) begin
              md_d = in_data;
            end else if (push && (SKID != 0)) begin
              // Head stalled: park the new payload behind it.
              state_d = ST_TWO;
              sd_d    = in_data;
            end else if (pop) begin
              state_d = ST_EMPTY;
              md_d    = '0;
            end
          end
          ST_TWO: begin
            if (pop) begin
              state_d = ST_ONE;
              md_d    = sd_q;
              sd_d    = '0;
            end
          end
          default: begin
            state_d = ST_EMPTY;
            md_d    = '0;
            sd_d    = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      md_q    <= '0;
      sd_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      sd_q    <= sd_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = mv;
  assign out_data  = md_q;
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Purpose  : Directed self-checking bench for pipe_stage_buf. Three instances
//            share one stimulus: SKID=1 (s1), SKID=0 (s0) and SKID=1 with a
//            2-bit drop counter (c2). Each scenario checks only the instance
//            it targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          en = 1'b1;
  logic          freeze = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;

  logic          s1_in_ready, s1_out_valid;
  logic [DW-1:0] s1_out_data;
  logic [15:0]   s1_drop;
  logic          s0_in_ready, s0_out_valid;
  logic [DW-1:0] s0_out_data;
  logic [15:0]   s0_drop;
  logic          c2_in_ready, c2_out_valid;
  logic [DW-1:0] c2_out_data;
  logic [1:0]    c2_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_s1 (
    .CLK(CLK), .nRST(nRST), .en(en), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s1_in_ready),
    .out_valid(s1_out_valid), .out_data(s1_out_data), .out_ready(out_ready),
    .drop_cnt(s1_drop)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(16)) u_s0 (
    .CLK(CLK), .nRST(nRST), .en(en), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s0_in_ready),
    .out_valid(s0_out_valid), .out_data(s0_out_data), .out_ready(out_ready),
    .drop_cnt(s0_drop)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(2)) u_c2 (
    .CLK(CLK), .nRST(nRST), .en(en), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(c2_in_ready),
    .out_valid(c2_out_valid), .out_data(c2_out_data), .out_ready(out_ready),
    .drop_cnt(c2_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST      = 1'b0;
    en        = 1'b1;
    freeze    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    // ---------------- reset and streaming ----------------
    nRST      = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    tick();
    tick();
    check("rst_out_valid", 32'(s1_out_valid), 32'd0);
    check("rst_out_data",  32'(s1_out_data),  32'd0);
    check("rst_in_ready",  32'(s1_in_ready),  32'd1);
    check("rst_drop",      32'(s1_drop),      32'd0);
    nRST     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("post_rst_in_ready", 32'(s1_in_ready), 32'd1);
    check("post_rst_s0_valid", 32'(s0_out_valid), 32'd0);

    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      tick();
      check("stream_s1_valid", 32'(s1_out_valid), 32'd1);
      check("stream_s1_data",  32'(s1_out_data),  32'(i));
      check("stream_s0_data",  32'(s0_out_data),  32'(i));
    end
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    check("drain_valid", 32'(s1_out_valid), 32'd0);
    check("drain_data",  32'(s1_out_data),  32'd0);

    // ---------------- skid backpressure (s1) ----------------
    in_valid = 1'b1;
    in_data  = 8'h0A;
    tick();
    check("skid_head_a", 32'(s1_out_data), 32'h0A);
    out_ready = 1'b0;
    in_data   = 8'h0B;
    #1;
    check("skid_ready_before", 32'(s1_in_ready), 32'd1);
    tick();
    check("skid_hold_a",   32'(s1_out_data), 32'h0A);
    check("skid_ready_lo", 32'(s1_in_ready), 32'd0);
    in_data = 8'h0C;
    tick();
    check("skid_still_a",   32'(s1_out_data), 32'h0A);
    check("skid_still_lo",  32'(s1_in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check("skid_out_b",    32'(s1_out_data), 32'h0B);
    check("skid_ready_hi", 32'(s1_in_ready), 32'd1);
    tick();
    check("skid_out_c", 32'(s1_out_data), 32'h0C);
    in_valid = 1'b0;
    tick();
    check("skid_empty", 32'(s1_out_valid), 32'd0);

    // ---------------- flush from TWO (s1) ----------------
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    check("flush_two_ready", 32'(s1_in_ready), 32'd0);
    check("flush_two_head",  32'(s1_out_data), 32'h11);
    in_data = 8'h33;
    flush   = 1'b1;
    tick();
    check("flush_valid", 32'(s1_out_valid), 32'd0);
    check("flush_data",  32'(s1_out_data),  32'd0);
    check("flush_drop",  32'(s1_drop),      32'd2);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("flush_no_33", 32'(s1_out_valid), 32'd0);

    // ---------------- freeze / en priority (s1) ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    tick();
    check("frz_loaded", 32'(s1_out_data), 32'h44);
    freeze    = 1'b1;
    flush     = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_data", 32'(s1_out_data), 32'h44);
      check("frz_drop", 32'(s1_drop),     32'd2);
    end
    freeze = 1'b0;
    en     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("en0_data", 32'(s1_out_data), 32'h44);
      check("en0_drop", 32'(s1_drop),     32'd2);
    end
    en       = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;

    // ---------------- SKID=0 passthrough (s0) ----------------
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    tick();
    check("s0_hold_55", 32'(s0_out_data), 32'h55);
    in_data = 8'h66;
    #1;
    check("s0_ready_lo", 32'(s0_in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("s0_ready_comb", 32'(s0_in_ready), 32'd1);
    check("s0_still_55",   32'(s0_out_data), 32'h55);
    tick();
    check("s0_out_66", 32'(s0_out_data), 32'h66);
    in_valid = 1'b0;
    tick();
    check("s0_empty", 32'(s0_out_valid), 32'd0);

    // ---------------- async reset mid-operation (c2) ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    check("arst_loaded", 32'(c2_out_valid), 32'd1);
    nRST = 1'b0;
    #1;
    check("arst_valid", 32'(c2_out_valid), 32'd0);
    check("arst_drop",  32'(c2_drop),      32'd0);

    // ---------------- counter saturation (c2) ----------------
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h01;
      flush    = 1'b0;
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      check("sat_drop", 32'(c2_drop), (k < 3) ? 32'(k) : 32'd3);
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
